frogger_game_fsm: RTL and testbench

- Top-level game sequencer sitting directly upstream of the frog movement controller.
- Produces the game-active enable consumed by the movement controller and consumes its collision and score results.
- Owns lives, the death freeze interval, the win/game-over decision and the score-clear request at new-game start.

---
 rtl/frogger_game_fsm.sv | 157 +++++++++++++++
 tb/tb_frogger_game_fsm.sv | 398 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/frogger_game_fsm.sv
// Frogger game sequencer: lives, death freeze, win / game-over, score clear.
// Optional round timer enabled by defining FROGGER_ROUND_TIMER_EN.
module frogger_game_fsm #(
    parameter int c_LIVES       = 3,
    parameter int c_WIN_SCORE   = 5,
    parameter int c_DEATH_TICKS = 25000000,
    parameter int c_ROUND_TICKS = 750000000
) (
    input  logic       i_Clk,
    input  logic       i_Rst,
    input  logic       i_Start,
    input  logic       i_Collided,
    input  logic [6:0] i_Score,
    output logic       o_Game_Active,
    output logic [1:0] o_Lives,
    output logic [2:0] o_State,
    output logic       o_Score_Clr,
    output logic       o_Timer_Expired
);

    localparam int c_DW = (c_DEATH_TICKS > 1) ? $clog2(c_DEATH_TICKS) : 1;
    localparam logic [c_DW-1:0] c_DEATH_LAST = c_DW'(c_DEATH_TICKS - 1);
    localparam logic [1:0] c_LIVES_INIT = 2'(c_LIVES);
    localparam logic [6:0] c_WIN = 7'(c_WIN_SCORE);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_PLAY      = 3'd1,
        S_DYING     = 3'd2,
        S_GAME_OVER = 3'd3,
        S_WIN       = 3'd4
    } state_t;

    state_t            state_q, state_d;
    logic [1:0]        lives_q, lives_d;
    logic [c_DW-1:0]   death_cnt_q, death_cnt_d;
    logic              start_q;
    logic              score_clr_q, score_clr_d;
    logic              game_active_q;
    logic              start_rise;
    logic              win;
    logic              round_expired;

    assign start_rise = i_Start & ~start_q;
    assign win        = (i_Score >= c_WIN);

    // Next-state, lives and freeze counter decode.
    always_comb begin
        state_d     = state_q;
        lives_d     = lives_q;
        death_cnt_d = death_cnt_q;
        score_clr_d = 1'b0;
        unique case (state_q)
            S_IDLE, S_GAME_OVER, S_WIN: begin
                if (start_rise) begin
                    state_d     = S_PLAY;
                    lives_d     = c_LIVES_INIT;
                    score_clr_d = 1'b1;
                end
            end
            S_PLAY: begin
                if (win) begin
                    state_d = S_WIN;
                end else if (i_Collided || round_expired) begin
                    state_d     = S_DYING;
                    lives_d     = lives_q - 2'd1;
                    death_cnt_d = '0;
                end
            end
            S_DYING: begin
                if (death_cnt_q == c_DEATH_LAST) begin
                    death_cnt_d = '0;
                    state_d = (lives_q == 2'd0) ? S_GAME_OVER : S_PLAY;
                end else begin
                    death_cnt_d = death_cnt_q + c_DW'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State, lives and registered output flops.
    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
            state_q       <= S_IDLE;
            lives_q       <= c_LIVES_INIT;
            death_cnt_q   <= '0;
            start_q       <= 1'b0;
            score_clr_q   <= 1'b0;
            game_active_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            lives_q       <= lives_d;
            death_cnt_q   <= death_cnt_d;
            start_q       <= i_Start;
            score_clr_q   <= score_clr_d;
            game_active_q <= (state_d == S_PLAY);
        end
    end

`ifdef FROGGER_ROUND_TIMER_EN
    localparam int c_RW = (c_ROUND_TICKS > 1) ? $clog2(c_ROUND_TICKS) : 1;
    localparam logic [c_RW-1:0] c_ROUND_LAST = c_RW'(c_ROUND_TICKS - 1);

    logic [c_RW-1:0] round_q, round_d;
    logic [6:0]      score_prev_q;
    logic            timer_exp_q, timer_exp_d;
    logic            score_changed;

    assign score_changed = (i_Score != score_prev_q);
    assign round_expired = (state_q == S_PLAY) && !score_changed
                         && (round_q == c_ROUND_LAST);

    // Round timer: restarts on PLAY entry and on any score progress.
    always_comb begin
        round_d     = round_q;
        timer_exp_d = 1'b0;
        if (state_q == S_PLAY) begin
            if (score_changed) begin
                round_d = '0;
            end else if (!round_expired) begin
                round_d = round_q + c_RW'(1);
            end
            timer_exp_d = round_expired && !win;
        end else if (state_d == S_PLAY) begin
            round_d = '0;
        end
    end

    // Round timer, score history and expiry pulse flops.
    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
            round_q      <= '0;
            score_prev_q <= '0;
            timer_exp_q  <= 1'b0;
        end else begin
            round_q      <= round_d;
            score_prev_q <= i_Score;
            timer_exp_q  <= timer_exp_d;
        end
    end

    assign o_Timer_Expired = timer_exp_q;
`else
    logic unused_round;

    assign unused_round    = ^c_ROUND_TICKS;
    assign round_expired   = 1'b0;
    assign o_Timer_Expired = 1'b0;
`endif

    assign o_Game_Active = game_active_q;
    assign o_Lives       = lives_q;
    assign o_State       = state_q;
    assign o_Score_Clr   = score_clr_q;

endmodule

// File: tb/tb_frogger_game_fsm.sv
// Bench for frogger_game_fsm: directed scenarios plus a randomized run
// against a behavioural game model.
module tb_frogger_game_fsm;

    localparam int LIVES = 3;
    localparam int WINS  = 5;
    localparam int DT    = 8;
    localparam int RT    = 20;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       st  = 1'b0;
    logic       col = 1'b0;
    logic [6:0] sc  = '0;
    logic       o_Game_Active;
    logic [1:0] o_Lives;
    logic [2:0] o_State;
    logic       o_Score_Clr;
    logic       o_Timer_Expired;

    int n_cmp = 0;
    int n_bad = 0;

    // behavioural model of the game
    int m_state;
    int m_lives;
    int m_freeze;
    int m_age;
    int m_pscore;
    bit m_pstart;
    bit m_clr;
    bit m_exp;

    frogger_game_fsm #(
        .c_LIVES(LIVES),
        .c_WIN_SCORE(WINS),
        .c_DEATH_TICKS(DT),
        .c_ROUND_TICKS(RT)
    ) dut (
        .i_Clk(clk),
        .i_Rst(rst),
        .i_Start(st),
        .i_Collided(col),
        .i_Score(sc),
        .o_Game_Active(o_Game_Active),
        .o_Lives(o_Lives),
        .o_State(o_State),
        .o_Score_Clr(o_Score_Clr),
        .o_Timer_Expired(o_Timer_Expired)
    );

    initial forever #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic model_reset();
        m_state  = 0;
        m_lives  = LIVES;
        m_freeze = 0;
        m_age    = 0;
        m_pscore = 0;
        m_pstart = 1'b0;
        m_clr    = 1'b0;
        m_exp    = 1'b0;
    endtask

    task automatic model_step(input bit s, input bit c, input int score);
        bit rise;
        bit tmo;
        rise = s && !m_pstart;
        tmo  = 1'b0;
        m_pstart = s;
        m_clr = 1'b0;
        m_exp = 1'b0;
        case (m_state)
            0, 3, 4: if (rise) begin
                m_state = 1;
                m_lives = LIVES;
                m_clr   = 1'b1;
                m_age   = 0;
            end
            1: begin
`ifdef FROGGER_ROUND_TIMER_EN
                if (score != m_pscore) m_age = 0;
                else if (m_age == RT - 1) tmo = 1'b1;
                else m_age++;
`endif
                if (score >= WINS) begin
                    m_state = 4;
                end else if (c || tmo) begin
                    m_state  = 2;
                    m_lives  = m_lives - 1;
                    m_freeze = DT;
                    m_exp    = tmo;
                end
            end
            2: begin
                m_freeze--;
                if (m_freeze == 0) begin
                    m_state = (m_lives == 0) ? 3 : 1;
                    m_age   = 0;
                end
            end
            default: m_state = 0;
        endcase
        m_pscore = score;
    endtask

    task automatic cycle();
        model_step(st, col, int'(sc));
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        st  = 1'b0;
        col = 1'b0;
        sc  = '0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
    endtask

    task automatic wait_dying(output int n);
        n = 0;
        while (o_State == 3'd2 && n < 100) begin
            n++;
            cycle();
        end
    endtask

    task automatic test_reset();
        #2 rst = 1'b1;
        #1;
        n_cmp++;
        if ({o_State, o_Lives, o_Game_Active, o_Score_Clr, o_Timer_Expired}
            !== {3'd0, 2'd3, 3'b000}) begin
            n_bad++;
            $display("FAIL reset_async: got st=%0d lv=%0d act=%0b clr=%0b exp=%0b",
                     o_State, o_Lives, o_Game_Active, o_Score_Clr, o_Timer_Expired);
        end
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
        cycle();
        n_cmp++;
        if (o_State !== 3'd0 || o_Game_Active !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_idle: got st=%0d act=%0b want st=0 act=0",
                     o_State, o_Game_Active);
        end
    endtask

    task automatic test_start_hold();
        int n_clr;
        int n_leave;
        do_reset();
        st = 1'b1;
        cycle();
        n_cmp++;
        if ({o_State, o_Lives, o_Game_Active, o_Score_Clr} !== {3'd1, 2'd3, 2'b11}) begin
            n_bad++;
            $display("FAIL start_enter: got st=%0d lv=%0d act=%0b clr=%0b",
                     o_State, o_Lives, o_Game_Active, o_Score_Clr);
        end
        n_clr = 0;
        n_leave = 0;
        for (int i = 0; i < 99; i++) begin
            sc = 7'(i % 3);
            cycle();
            if (o_Score_Clr) n_clr++;
            if (o_State != 3'd1 || !o_Game_Active) n_leave++;
        end
        n_cmp++;
        if (n_clr !== 0 || n_leave !== 0) begin
            n_bad++;
            $display("FAIL start_hold: got extra_clr=%0d not_play=%0d want 0 0",
                     n_clr, n_leave);
        end
        sc = '0;
    endtask

    task automatic test_death();
        int n;
        do_reset();
        st = 1'b1;
        cycle();
        st = 1'b0;
        col = 1'b1;
        cycle();
        col = 1'b0;
        n_cmp++;
        if ({o_State, o_Lives, o_Game_Active} !== {3'd2, 2'd2, 1'b0}) begin
            n_bad++;
            $display("FAIL death_enter: got st=%0d lv=%0d act=%0b want 2 2 0",
                     o_State, o_Lives, o_Game_Active);
        end
        col = 1'b1;
        wait_dying(n);
        col = 1'b0;
        n_cmp++;
        if (n !== DT) begin
            n_bad++;
            $display("FAIL death_len: got %0d cycles want %0d", n, DT);
        end
        n_cmp++;
        if ({o_State, o_Lives, o_Game_Active} !== {3'd1, 2'd2, 1'b1}) begin
            n_bad++;
            $display("FAIL death_return: got st=%0d lv=%0d act=%0b want 1 2 1",
                     o_State, o_Lives, o_Game_Active);
        end
    endtask

    task automatic test_game_over();
        int n;
        do_reset();
        st = 1'b1;
        cycle();
        st = 1'b0;
        for (int k = 0; k < 3; k++) begin
            col = 1'b1;
            cycle();
            col = 1'b0;
            n_cmp++;
            if (o_State !== 3'd2 || o_Lives !== 2'(2 - k)) begin
                n_bad++;
                $display("FAIL go_hit%0d: got st=%0d lv=%0d want 2 %0d",
                         k, o_State, o_Lives, 2 - k);
            end
            wait_dying(n);
        end
        n_cmp++;
        if ({o_State, o_Lives, o_Game_Active} !== {3'd3, 2'd0, 1'b0}) begin
            n_bad++;
            $display("FAIL go_state: got st=%0d lv=%0d act=%0b want 3 0 0",
                     o_State, o_Lives, o_Game_Active);
        end
        for (int i = 0; i < 4; i++) begin
            col = i[0];
            cycle();
        end
        col = 1'b0;
        n_cmp++;
        if (o_State !== 3'd3 || o_Lives !== 2'd0) begin
            n_bad++;
            $display("FAIL go_hold: got st=%0d lv=%0d want 3 0", o_State, o_Lives);
        end
        st = 1'b1;
        cycle();
        n_cmp++;
        if ({o_State, o_Lives, o_Game_Active, o_Score_Clr} !== {3'd1, 2'd3, 2'b11}) begin
            n_bad++;
            $display("FAIL go_restart: got st=%0d lv=%0d act=%0b clr=%0b",
                     o_State, o_Lives, o_Game_Active, o_Score_Clr);
        end
        cycle();
        n_cmp++;
        if (o_Score_Clr !== 1'b0) begin
            n_bad++;
            $display("FAIL go_clr_pulse: got %0b want 0", o_Score_Clr);
        end
        st = 1'b0;
    endtask

    task automatic test_win();
        sc = 7'd4;
        cycle();
        n_cmp++;
        if (o_State !== 3'd1) begin
            n_bad++;
            $display("FAIL win_below: got st=%0d want 1", o_State);
        end
        sc = 7'd5;
        col = 1'b1;
        cycle();
        col = 1'b0;
        n_cmp++;
        if ({o_State, o_Lives, o_Game_Active} !== {3'd4, 2'd3, 1'b0}) begin
            n_bad++;
            $display("FAIL win_over_hit: got st=%0d lv=%0d act=%0b want 4 3 0",
                     o_State, o_Lives, o_Game_Active);
        end
        sc = '0;
    endtask

    task automatic test_reset_mid_dying();
        do_reset();
        st = 1'b1;
        cycle();
        st = 1'b0;
        col = 1'b1;
        cycle();
        col = 1'b0;
        cycle();
        cycle();
        n_cmp++;
        if (o_State !== 3'd2) begin
            n_bad++;
            $display("FAIL rst_pre: got st=%0d want 2", o_State);
        end
        #2 rst = 1'b1;
        #1;
        n_cmp++;
        if ({o_State, o_Lives, o_Game_Active, o_Score_Clr, o_Timer_Expired}
            !== {3'd0, 2'd3, 3'b000}) begin
            n_bad++;
            $display("FAIL rst_mid_dying: got st=%0d lv=%0d act=%0b clr=%0b exp=%0b",
                     o_State, o_Lives, o_Game_Active, o_Score_Clr, o_Timer_Expired);
        end
    endtask

`ifdef FROGGER_ROUND_TIMER_EN
    task automatic test_timer();
        int n;
        do_reset();
        st = 1'b1;
        cycle();
        st = 1'b0;
        n = 0;
        while (o_State == 3'd1 && n < 100) begin
            n++;
            cycle();
        end
        n_cmp++;
        if (n !== RT || {o_State, o_Lives, o_Timer_Expired} !== {3'd2, 2'd2, 1'b1}) begin
            n_bad++;
            $display("FAIL timer_expire: got play=%0d st=%0d lv=%0d exp=%0b want %0d 2 2 1",
                     n, o_State, o_Lives, o_Timer_Expired, RT);
        end
        cycle();
        n_cmp++;
        if (o_Timer_Expired !== 1'b0) begin
            n_bad++;
            $display("FAIL timer_pulse: got %0b want 0", o_Timer_Expired);
        end
        wait_dying(n);
        for (int i = 0; i < 14; i++) cycle();
        sc = 7'd1;
        n = 0;
        cycle();
        while (o_State == 3'd1 && n < 100) begin
            n++;
            cycle();
        end
        n_cmp++;
        if (n !== RT || o_Timer_Expired !== 1'b1 || o_Lives !== 2'd1) begin
            n_bad++;
            $display("FAIL timer_restart: got play=%0d exp=%0b lv=%0d want %0d 1 1",
                     n, o_Timer_Expired, o_Lives, RT);
        end
        sc = '0;
    endtask
`endif

    task automatic test_random();
        logic [7:0] got;
        logic [7:0] want;
        do_reset();
        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(0, 7) == 0) st = ~st;
            col = ($urandom_range(0, 5) == 0);
            if (m_clr) sc = '0;
            else if ($urandom_range(0, 9) == 0) sc = 7'($urandom_range(0, 6));
            cycle();
            got  = {o_State, o_Lives, o_Game_Active, o_Score_Clr, o_Timer_Expired};
            want = {3'(m_state), 2'(m_lives), m_state == 1, m_clr, m_exp};
            n_cmp++;
            if (got !== want) begin
                n_bad++;
                $display("FAIL random[%0d]: got %b want %b (st,lv,act,clr,exp)",
                         i, got, want);
            end
        end
    endtask

    initial begin
        test_reset();
        test_start_hold();
        test_death();
        test_game_over();
        test_win();
        test_reset_mid_dying();
`ifdef FROGGER_ROUND_TIMER_EN
        test_timer();
`endif
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
